// File: rtl/core_pkg.sv
// Shared core definitions: FU ids, default FU timing configuration and the
// layout width of one writeback reservation slot.
package core_pkg;

  localparam int FU_NONE = 0;
  localparam int FU_ALU  = 1;
  localparam int FU_MEM  = 2;
  localparam int FU_MUL  = 3;
  localparam int FU_DIV  = 4;
  localparam int FU_JUMP = 5;

  localparam int NUM_FU_DEF = 5;
  localparam int LAT_W_DEF  = 5;
  localparam int RD_W       = 5;

  localparam logic [NUM_FU_DEF*LAT_W_DEF-1:0] FU_LAT_DEF  = {5'd24, 5'd7, 5'd2, 5'd2, 5'd1};
  localparam logic [NUM_FU_DEF-1:0]           FU_PIPE_DEF = 5'b00100;

  // Slot layout, MSB first: {v, fu, rd, we}
  function automatic int slot_width(input int num_fu);
    return 1 + $clog2(num_fu + 1) + RD_W + 1;
  endfunction

endpackage

// File: rtl/wb_reservation_shifter.sv
// Writeback reservation shift register: shifts toward slot 0 every cycle,
// with one write port that overrides the shift at the written index.
module wb_reservation_shifter #(
  parameter int DEPTH = 32,
  parameter int W     = 10,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [W-1:0]     head_o,
  output logic [W-1:0]     peek_o
);

  logic [DEPTH-1:0][W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q >> W;
    if (wr_en_i) slot_d[wr_idx_i] = wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign head_o = slot_q[0];
  assign peek_o = slot_q[rd_idx_i];

endmodule

// File: rtl/fu_wb_scoreboard.sv
// Issue/writeback scoreboard: RAW/WAW/FU-busy/writeback-slot hazard checks and
// scheduling of every FU result onto the single writeback port.
module fu_wb_scoreboard
  import core_pkg::*;
#(
  parameter int                       NUM_FU  = NUM_FU_DEF,
  parameter int                       DEPTH   = 32,
  parameter int                       LAT_W   = LAT_W_DEF,
  parameter logic [NUM_FU*LAT_W-1:0]  FU_LAT  = FU_LAT_DEF,
  parameter logic [NUM_FU-1:0]        FU_PIPE = FU_PIPE_DEF,
  localparam int FU_W  = $clog2(NUM_FU + 1),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [FU_W-1:0]   issue_fu,
  input  logic [4:0]        issue_rd,
  input  logic              issue_we,
  input  logic [4:0]        issue_rs1,
  input  logic [4:0]        issue_rs2,
  input  logic              issue_rs1_used,
  input  logic              issue_rs2_used,
  input  logic              flush,
  output logic              issue_ready,
  output logic              issue_fire,
  output logic              haz_raw,
  output logic              haz_waw,
  output logic              haz_struct,
  output logic              wb_valid,
  output logic [FU_W-1:0]   wb_fu,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [NUM_FU-1:0] fu_busy,
  output logic [CNT_W-1:0]  inflight
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = slot_width(NUM_FU);

  logic [SW-1:0]     head, peek, wr_slot;
  logic [IDX_W-1:0]  wr_idx, peek_idx;
  logic [31:0]       pend_q, pend_d, pend_eff, wb_clr;
  logic [NUM_FU-1:0] busy_q, busy_d, busy_eff, wb_fu_oh, iss_fu_oh;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat;
  logic              pipe, fu_sel, we_eff, slot_hit, fire_fu, raw, waw, strc;

  assign wb_valid = head[SW-1];
  assign wb_fu    = head[SW-2 -: FU_W];
  assign wb_rd    = head[RD_W:1];
  assign wb_we    = head[0];

  always_comb begin
    lat       = '0;
    pipe      = 1'b0;
    iss_fu_oh = '0;
    wb_fu_oh  = '0;
    for (int f = 1; f <= NUM_FU; f++) begin
      if (issue_fu == FU_W'(f)) begin
        lat          = FU_LAT[(f-1)*LAT_W +: LAT_W];
        pipe         = FU_PIPE[f-1];
        iss_fu_oh[f-1] = 1'b1;
      end
      if (wb_fu == FU_W'(f)) wb_fu_oh[f-1] = 1'b1;
    end
  end

  // The retiring slot's register and FU count as free this cycle (write-first RF)
  assign wb_clr   = (wb_valid && wb_we) ? (32'd1 << wb_rd) : 32'd0;
  assign pend_eff = pend_q & ~wb_clr;
  assign busy_eff = busy_q & ~({NUM_FU{wb_valid}} & wb_fu_oh);

  assign fu_sel   = issue_valid & (issue_fu != FU_W'(FU_NONE));
  assign we_eff   = issue_we & (issue_rd != 5'd0);
  assign peek_idx = IDX_W'(lat);
  assign wr_idx   = IDX_W'(lat - 1'b1);
  // Pre-shift slot[L] is what would land on slot[L-1] this edge
  assign slot_hit = (int'(lat) < DEPTH) & peek[SW-1];

  assign raw  = fu_sel & ((issue_rs1_used & pend_eff[issue_rs1]) |
                          (issue_rs2_used & pend_eff[issue_rs2]));
  assign waw  = fu_sel & we_eff & pend_eff[issue_rd];
  assign strc = fu_sel & (slot_hit | (~pipe & |(busy_eff & iss_fu_oh)));

  assign haz_raw     = raw;
  assign haz_waw     = waw;
  assign haz_struct  = strc;
  assign issue_ready = ~(raw | waw | strc);
  assign issue_fire  = issue_valid & issue_ready & ~flush;
  assign fire_fu     = issue_fire & (issue_fu != FU_W'(FU_NONE));
  assign wr_slot     = {1'b1, issue_fu, issue_rd, we_eff};

  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (fire_fu && we_eff) pend_d[issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
    busy_d = busy_q & ~({NUM_FU{wb_valid}} & wb_fu_oh);
    if (fire_fu && !pipe) busy_d = busy_d | iss_fu_oh;
    cnt_d = cnt_q + CNT_W'(fire_fu) - CNT_W'(wb_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fu_busy  = busy_q;
  assign inflight = cnt_q;

  wb_reservation_shifter #(
    .DEPTH (DEPTH),
    .W     (SW),
    .IDX_W (IDX_W)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fire_fu),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_slot),
    .rd_idx_i  (peek_idx),
    .head_o    (head),
    .peek_o    (peek)
  );

endmodule

// File: tb/tb_fu_wb_scoreboard.sv
// Directed bench for fu_wb_scoreboard with ALU=1, MEM=2, MUL=7, DIV=24, JUMP=2.
module tb_fu_wb_scoreboard;
  import core_pkg::*;

  localparam logic [24:0] TB_LAT = {5'd2, 5'd24, 5'd7, 5'd2, 5'd1};

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_we, issue_rs1_used, issue_rs2_used, flush;
  logic [2:0] issue_fu;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic       issue_ready, issue_fire, haz_raw, haz_waw, haz_struct;
  logic       wb_valid, wb_we;
  logic [2:0] wb_fu;
  logic [4:0] wb_rd;
  logic [4:0] fu_busy;
  logic [5:0] inflight;

  int checks = 0;
  int failures = 0;
  logic seen;

  fu_wb_scoreboard #(
    .NUM_FU (5), .DEPTH (32), .LAT_W (5), .FU_LAT (TB_LAT), .FU_PIPE (5'b00100)
  ) dut (
    .clk (clk), .rst (rst),
    .issue_valid (issue_valid), .issue_fu (issue_fu), .issue_rd (issue_rd),
    .issue_we (issue_we), .issue_rs1 (issue_rs1), .issue_rs2 (issue_rs2),
    .issue_rs1_used (issue_rs1_used), .issue_rs2_used (issue_rs2_used),
    .flush (flush), .issue_ready (issue_ready), .issue_fire (issue_fire),
    .haz_raw (haz_raw), .haz_waw (haz_waw), .haz_struct (haz_struct),
    .wb_valid (wb_valid), .wb_fu (wb_fu), .wb_rd (wb_rd), .wb_we (wb_we),
    .fu_busy (fu_busy), .inflight (inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_fu = 0; issue_rd = 0; issue_we = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0; issue_rs2_used = 0;
  endtask

  task automatic iss(input int fu, input int rd, input bit we,
                     input int rs1, input bit u1, input int rs2, input bit u2);
    issue_valid = 1; issue_fu = 3'(fu); issue_rd = 5'(rd); issue_we = we;
    issue_rs1 = 5'(rs1); issue_rs1_used = u1; issue_rs2 = 5'(rs2); issue_rs2_used = u2;
  endtask

  initial begin
    rst = 1; flush = 0; idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_fu_busy", fu_busy, 0);
    rst = 0;

    // Basic ALU issue, then flushed reader of r5, then fu=0 issue
    @(negedge clk); iss(FU_ALU, 5, 1, 0, 0, 0, 0); #1;
    chk("alu_fire", issue_fire, 1);
    @(negedge clk); idle(); #1;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_rd", wb_rd, 5);
    chk("alu_wb_fu", wb_fu, 1);
    chk("alu_inflight", inflight, 1);
    @(negedge clk); iss(FU_ALU, 6, 1, 5, 1, 0, 0); flush = 1; #1;
    chk("p5_clear_raw", haz_raw, 0);
    chk("flush_ready", issue_ready, 1);
    chk("flush_fire", issue_fire, 0);
    @(negedge clk); flush = 0; idle(); #1;
    chk("flush_inflight", inflight, 0);
    chk("flush_no_wb", wb_valid, 0);
    @(negedge clk); iss(FU_NONE, 7, 1, 0, 0, 0, 0); #1;
    chk("fu0_fire", issue_fire, 1);
    @(negedge clk); idle(); #1;
    chk("fu0_inflight", inflight, 0);
    @(negedge clk); #1;
    chk("fu0_no_wb", wb_valid, 0);

    // RAW stall behind DIV rd=3
    @(negedge clk); iss(FU_DIV, 3, 1, 0, 0, 0, 0); #1;
    chk("div_fire", issue_fire, 1);
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk); iss(FU_ALU, 6, 1, 3, 1, 0, 0); #1;
      chk("raw_stall", haz_raw, 1);
      chk("raw_ready", issue_ready, 0);
    end
    @(negedge clk); #1;
    chk("raw_release", haz_raw, 0);
    chk("raw_fire_wb", issue_fire, 1);
    chk("div_wb_rd", wb_rd, 3);
    chk("div_wb_fu", wb_fu, 4);
    @(negedge clk); idle(); #1;
    chk("add_wb_rd", wb_rd, 6);
    chk("add_wb_valid", wb_valid, 1);

    // Writeback-slot collision MEM(L=2) then ALU(L=1)
    @(negedge clk); iss(FU_MEM, 7, 1, 0, 0, 0, 0); #1;
    chk("mem_fire", issue_fire, 1);
    @(negedge clk); iss(FU_ALU, 8, 1, 0, 0, 0, 0); #1;
    chk("coll_struct", haz_struct, 1);
    chk("coll_fire", issue_fire, 0);
    @(negedge clk); #1;
    chk("coll_fire_t2", issue_fire, 1);
    chk("mem_wb_fu", wb_fu, 2);
    chk("mem_wb_rd", wb_rd, 7);
    @(negedge clk); idle(); #1;
    chk("coll_alu_wb", wb_rd, 8);

    // Pipelined MUL back-to-back
    @(negedge clk); iss(FU_MUL, 1, 1, 0, 0, 0, 0); #1;
    chk("mul1_fire", issue_fire, 1);
    @(negedge clk); iss(FU_MUL, 2, 1, 0, 0, 0, 0); #1;
    chk("mul2_fire", issue_fire, 1);
    @(negedge clk); idle(); #1;
    chk("mul_inflight", inflight, 2);
    chk("mul_not_busy", fu_busy, 0);
    repeat (4) @(negedge clk);
    #1 chk("mul_t6_no_wb", wb_valid, 0);
    @(negedge clk); #1;
    chk("mul1_wb_valid", wb_valid, 1);
    chk("mul1_wb_rd", wb_rd, 1);
    chk("mul1_wb_fu", wb_fu, 3);
    @(negedge clk); #1;
    chk("mul2_wb_rd", wb_rd, 2);
    @(negedge clk); #1;
    chk("mul_drained", inflight, 0);

    // Non-pipelined DIV re-issue
    @(negedge clk); iss(FU_DIV, 9, 1, 0, 0, 0, 0); #1;
    chk("div1_fire", issue_fire, 1);
    @(negedge clk); iss(FU_DIV, 10, 1, 0, 0, 0, 0); #1;
    chk("div_busy_struct", haz_struct, 1);
    chk("div_fu_busy", fu_busy, 5'b01000);
    for (int c = 2; c <= 23; c++) begin
      @(negedge clk); #1;
      chk("div_stall", issue_ready, 0);
    end
    @(negedge clk); #1;
    chk("div2_fire", issue_fire, 1);
    chk("div1_wb_rd", wb_rd, 9);
    @(negedge clk); idle(); #1;
    chk("div2_busy", fu_busy, 5'b01000);
    repeat (22) @(negedge clk);
    #1 chk("div2_early", wb_valid, 0);
    @(negedge clk); #1;
    chk("div2_wb_valid", wb_valid, 1);
    chk("div2_wb_rd", wb_rd, 10);
    @(negedge clk); #1;
    chk("div2_busy_clr", fu_busy, 0);

    // WAW behind MUL rd=4, rd=0 and unused-source boundaries
    @(negedge clk); iss(FU_MUL, 4, 1, 0, 0, 0, 0); #1;
    chk("waw_mul_fire", issue_fire, 1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); iss(FU_ALU, 4, 1, 0, 0, 0, 0); #1;
      chk("waw_stall", haz_waw, 1);
    end
    @(negedge clk); #1;
    chk("waw_release", haz_waw, 0);
    chk("waw_fire", issue_fire, 1);
    chk("waw_wb_rd", wb_rd, 4);
    @(negedge clk); idle(); #1;
    chk("waw_alu_wb_fu", wb_fu, 1);
    @(negedge clk); iss(FU_MUL, 0, 1, 0, 0, 0, 0); #1;                 // t9
    chk("rd0_mul_fire", issue_fire, 1);
    @(negedge clk); iss(FU_ALU, 0, 1, 0, 1, 0, 1); #1;                 // t10
    chk("rd0_no_waw", haz_waw, 0);
    chk("rd0_no_raw", haz_raw, 0);
    @(negedge clk); iss(FU_MUL, 13, 1, 0, 0, 0, 0); #1;                // t11
    chk("mul13_fire", issue_fire, 1);
    @(negedge clk); iss(FU_ALU, 14, 1, 13, 0, 13, 0); #1;              // t12
    chk("unused_src_raw", haz_raw, 0);
    @(negedge clk); iss(FU_ALU, 14, 1, 0, 0, 13, 1); #1;               // t13
    chk("rs2_raw", haz_raw, 1);
    chk("rs2_fire", issue_fire, 0);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk); #1;                                                 // t16
    chk("rd0_wb_valid", wb_valid, 1);
    chk("rd0_wb_we", wb_we, 0);
    repeat (4) @(negedge clk);
    #1 chk("waw_drained", inflight, 0);

    // Reset during an in-flight DIV
    @(negedge clk); iss(FU_DIV, 11, 1, 0, 0, 0, 0); #1;
    chk("rst_div_fire", issue_fire, 1);
    repeat (5) @(negedge clk) idle();
    #2 rst = 1;
    #1;
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_busy", fu_busy, 0);
    chk("mid_rst_wb", wb_valid, 0);
    chk("mid_rst_ready", issue_ready, 1);
    @(negedge clk); rst = 0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (wb_valid) seen = 1;
    end
    chk("rst_no_late_wb", seen, 0);
    iss(FU_ALU, 15, 1, 11, 1, 0, 0); #1;
    chk("rst_pend_clr", haz_raw, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
